// File: rtl/h264invtransform_controller.sv
// Sequencing controller for the 4x4 inverse core transform: accepts four coefficient rows,
// flushes the vertical stage, then streams four residual columns through a two-stage output pipe.
module h264invtransform_controller (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       ENABLE,
    input  logic       COEF_VALID,
    output logic       COEF_READY,
    input  logic       RES_READY,
    output logic       RES_VALID,
    output logic       RES_LAST,
    output logic       en_dequant,
    output logic       en_vert,
    output logic       en_horz,
    output logic       en_round,
    output logic [1:0] row_wr,
    output logic [1:0] col_rd,
    output logic       busy,
    output logic       blk_done
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_VFLUSH = 2'd2,
        ST_OUT    = 2'd3
    } state_t;

    state_t     state_r;
    state_t     state_next_s;
    logic       coef_ready_s;
    logic       row_hs_s;
    logic       en_horz_s;
    logic       en_round_s;
    logic       blk_end_s;
    logic       busy_s;
    logic [1:0] row_cnt_r;
    logic       en_vert_r;
    logic [1:0] row_wr_r;
    logic [2:0] cols_issued_r;
    logic       v_h_r;
    logic [1:0] hcol_r;
    logic       res_valid_r;
    logic       res_last_r;
    logic       blk_done_r;

    // State register
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic; a started block always runs to its last column handshake
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (ENABLE) state_next_s = ST_LOAD;
                else        state_next_s = ST_IDLE;
            end
            ST_LOAD: begin
                if (row_hs_s && (row_cnt_r == 2'd3)) state_next_s = ST_VFLUSH;
                else                                 state_next_s = ST_LOAD;
            end
            ST_VFLUSH: begin
                state_next_s = ST_OUT;
            end
            ST_OUT: begin
                if (blk_end_s) state_next_s = ENABLE ? ST_LOAD : ST_IDLE;
                else           state_next_s = ST_OUT;
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Handshake and stage-enable decode
    always_comb begin
        coef_ready_s = (state_r == ST_LOAD);
        row_hs_s     = coef_ready_s & COEF_VALID;
        en_round_s   = (state_r == ST_OUT) & v_h_r & (~res_valid_r | RES_READY);
        en_horz_s    = (state_r == ST_OUT) & ~cols_issued_r[2] & (~v_h_r | en_round_s);
        blk_end_s    = res_valid_r & RES_READY & res_last_r;
        busy_s       = (state_r != ST_IDLE);
    end

    // Row counter and registered vertical-stage enable with its row index
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            row_cnt_r <= 2'd0;
            en_vert_r <= 1'b0;
            row_wr_r  <= 2'd0;
        end else begin
            en_vert_r <= row_hs_s;
            if (blk_end_s) begin
                row_cnt_r <= 2'd0;
            end else if (row_hs_s) begin
                row_cnt_r <= row_cnt_r + 2'd1;
            end
            if (row_hs_s) begin
                row_wr_r <= row_cnt_r;
            end
        end
    end

    // Column pipe: issue counter, horizontal-stage valid, output register valid/last
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            cols_issued_r <= 3'd0;
            v_h_r         <= 1'b0;
            hcol_r        <= 2'd0;
            res_valid_r   <= 1'b0;
            res_last_r    <= 1'b0;
            blk_done_r    <= 1'b0;
        end else begin
            if (blk_end_s) begin
                cols_issued_r <= 3'd0;
            end else if (en_horz_s) begin
                cols_issued_r <= cols_issued_r + 3'd1;
            end
            if (en_horz_s) begin
                hcol_r <= cols_issued_r[1:0];
            end
            v_h_r       <= en_horz_s | (v_h_r & ~en_round_s);
            res_valid_r <= en_round_s | (res_valid_r & ~RES_READY);
            if (en_round_s) begin
                res_last_r <= (hcol_r == 2'd3);
            end else if (res_valid_r && !RES_READY) begin
                res_last_r <= res_last_r;
            end else begin
                res_last_r <= 1'b0;
            end
            blk_done_r <= blk_end_s;
        end
    end

    assign COEF_READY = coef_ready_s;
    assign en_dequant = row_hs_s;
    assign en_vert    = en_vert_r;
    assign row_wr     = row_wr_r;
    assign en_horz    = en_horz_s;
    assign col_rd     = cols_issued_r[1:0];
    assign en_round   = en_round_s;
    assign RES_VALID  = res_valid_r;
    assign RES_LAST   = res_last_r;
    assign busy       = busy_s;
    assign blk_done   = blk_done_r;

endmodule

// File: tb/tb_h264invtransform_controller.sv
// Self-checking bench for h264invtransform_controller: directed timing scenarios plus a
// randomized run checked against a queue-based transaction model.
module tb_h264invtransform_controller;

    logic       CLK = 1'b0;
    logic       RESET, ENABLE, COEF_VALID, RES_READY;
    logic       COEF_READY, RES_VALID, RES_LAST;
    logic       en_dequant, en_vert, en_horz, en_round, busy, blk_done;
    logic [1:0] row_wr, col_rd;
    int         errors = 0;
    int         checks = 0;

    h264invtransform_controller dut (
        .CLK(CLK), .RESET(RESET), .ENABLE(ENABLE), .COEF_VALID(COEF_VALID),
        .COEF_READY(COEF_READY), .RES_READY(RES_READY), .RES_VALID(RES_VALID),
        .RES_LAST(RES_LAST), .en_dequant(en_dequant), .en_vert(en_vert),
        .en_horz(en_horz), .en_round(en_round), .row_wr(row_wr), .col_rd(col_rd),
        .busy(busy), .blk_done(blk_done)
    );

    always #5 CLK = ~CLK;

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RESET = 1'b0; ENABLE = 1'b0; COEF_VALID = 1'b0; RES_READY = 1'b0;
        cyc(); cyc();
        RESET = 1'b1;
        cyc();
    endtask

    task automatic test_reset();
        RESET = 1'b0; ENABLE = 1'b1; COEF_VALID = 1'b1; RES_READY = 1'b1;
        cyc(); #3;
        checks++;
        if ({COEF_READY, RES_VALID, RES_LAST, en_dequant, en_vert, en_horz, en_round,
             row_wr, col_rd, busy, blk_done} !== 13'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected all zero",
                     {COEF_READY, RES_VALID, RES_LAST, en_dequant, en_vert, en_horz, en_round,
                      row_wr, col_rd, busy, blk_done});
        end
        ENABLE = 1'b0;
        cyc();
        RESET = 1'b1;
        cyc(); #3;
        checks++;
        if (COEF_READY !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: got ready=%b busy=%b expected 0 0", COEF_READY, busy);
        end
        ENABLE = 1'b1;
        cyc(); #3;
        checks++;
        if (COEF_READY !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL idle_to_load: got ready=%b busy=%b expected 1 1", COEF_READY, busy);
        end
    endtask

    task automatic test_back_to_back();
        logic [8:0] got, exp;
        do_reset();
        ENABLE = 1'b1; COEF_VALID = 1'b1; RES_READY = 1'b1;
        cyc();
        for (int k = 0; k <= 11; k++) begin
            #3;
            // order: dequant, ready, vert, horz, round, valid, last, done, busy
            exp = {((k <= 3) || (k == 11)), ((k <= 3) || (k == 11)), (k >= 1 && k <= 4),
                   (k >= 5 && k <= 8), (k >= 6 && k <= 9), (k >= 7 && k <= 10),
                   (k == 10), (k == 11), 1'b1};
            got = {en_dequant, COEF_READY, en_vert, en_horz, en_round, RES_VALID,
                   RES_LAST, blk_done, busy};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL b2b_enables k=%0d: got %b expected %b", k, got, exp);
            end
            if (k >= 1 && k <= 4) begin
                checks++;
                if (row_wr !== 2'(k - 1)) begin
                    errors++;
                    $display("FAIL b2b_row_wr k=%0d: got %0d expected %0d", k, row_wr, k - 1);
                end
            end
            if (k >= 5 && k <= 8) begin
                checks++;
                if (col_rd !== 2'(k - 5)) begin
                    errors++;
                    $display("FAIL b2b_col_rd k=%0d: got %0d expected %0d", k, col_rd, k - 5);
                end
            end
            cyc();
        end
    endtask

    task automatic test_gaps();
        bit   pat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        bit   prev = 1'b0;
        bit   e;
        int   nacc = 0;
        int   vidx = 0;
        int   waited;
        do_reset();
        ENABLE = 1'b1; RES_READY = 1'b1;
        cyc();
        for (int i = 0; i <= 8; i++) begin
            e = (i < 7) ? pat[i] : 1'b0;
            COEF_VALID = e;
            #3;
            if (i < 7) begin
                checks++;
                if (en_dequant !== e || COEF_READY !== 1'b1) begin
                    errors++;
                    $display("FAIL gap_dequant i=%0d: got deq=%b ready=%b expected %b 1",
                             i, en_dequant, COEF_READY, e);
                end
            end
            checks++;
            if (en_vert !== prev) begin
                errors++;
                $display("FAIL gap_vert i=%0d: got %b expected %b", i, en_vert, prev);
            end
            if (prev) begin
                checks++;
                if (row_wr !== 2'(vidx)) begin
                    errors++;
                    $display("FAIL gap_row_wr i=%0d: got %0d expected %0d", i, row_wr, vidx);
                end
                vidx++;
            end
            if (i == 7) begin
                checks++;
                if (COEF_READY !== 1'b0 || en_horz !== 1'b0 || busy !== 1'b1) begin
                    errors++;
                    $display("FAIL gap_vflush: got ready=%b horz=%b busy=%b expected 0 0 1",
                             COEF_READY, en_horz, busy);
                end
            end
            if (i == 8) begin
                checks++;
                if (en_horz !== 1'b1 || col_rd !== 2'd0) begin
                    errors++;
                    $display("FAIL gap_first_issue: got horz=%b col=%0d expected 1 0", en_horz, col_rd);
                end
            end
            if (en_dequant === 1'b1) nacc++;
            prev = (i < 7) && e;
            if (i == 6) ENABLE = 1'b0;
            cyc();
        end
        checks++;
        if (nacc != 4) begin
            errors++;
            $display("FAIL gap_count: got %0d expected 4", nacc);
        end
        waited = 0;
        while (blk_done !== 1'b1 && waited < 20) begin
            cyc(); waited++;
        end
        checks++;
        if (waited >= 20) begin
            errors++;
            $display("FAIL gap_complete: got no blk_done expected one within 20 cycles");
        end
    endtask

    task automatic test_backpressure();
        int q_h[$];
        int q_o[$];
        int c;
        int hs = 0, issued = 0, stall = 0, stall_seen = 0, done_n = 0;
        bit seen = 1'b0;
        do_reset();
        ENABLE = 1'b1; COEF_VALID = 1'b1; RES_READY = 1'b1;
        cyc();
        ENABLE = 1'b0;
        for (int k = 0; k < 40 && done_n == 0; k++) begin
            if (RES_VALID === 1'b1 && !seen) begin
                seen = 1'b1;
                stall = 5;
            end
            RES_READY = (stall == 0);
            #3;
            if (stall > 0) begin
                stall--;
                stall_seen++;
                checks++;
                if ({RES_VALID, RES_LAST, en_horz, en_round} !== 4'b1000) begin
                    errors++;
                    $display("FAIL bp_stall k=%0d: got valid,last,horz,round=%b expected 1000",
                             k, {RES_VALID, RES_LAST, en_horz, en_round});
                end
            end
            if (RES_VALID === 1'b1 && RES_READY === 1'b1) begin
                if (q_o.size() == 0) begin
                    c = -1;
                end else begin
                    c = q_o.pop_front();
                end
                checks++;
                if (c != hs || RES_LAST !== (c == 3)) begin
                    errors++;
                    $display("FAIL bp_handshake: got col=%0d last=%b expected col=%0d last=%b",
                             c, RES_LAST, hs, (hs == 3));
                end
                hs++;
            end
            if (en_round === 1'b1 && q_h.size() > 0) q_o.push_back(q_h.pop_front());
            if (en_horz === 1'b1) begin
                checks++;
                if (col_rd !== 2'(issued)) begin
                    errors++;
                    $display("FAIL bp_issue: got col_rd=%0d expected %0d", col_rd, issued);
                end
                q_h.push_back(int'(col_rd));
                issued++;
            end
            if (blk_done === 1'b1) done_n++;
            cyc();
        end
        checks++;
        if (hs != 4 || issued != 4 || stall_seen != 5 || done_n != 1) begin
            errors++;
            $display("FAIL bp_totals: got hs=%0d issued=%0d stalls=%0d done=%0d expected 4 4 5 1",
                     hs, issued, stall_seen, done_n);
        end
    endtask

    task automatic test_enable_drop();
        int nacc = 0, hs = 0;
        bit done_seen = 1'b0;
        do_reset();
        ENABLE = 1'b1; COEF_VALID = 1'b1; RES_READY = 1'b1;
        cyc();
        for (int k = 0; k < 30 && !done_seen; k++) begin
            #3;
            if (en_dequant === 1'b1) nacc++;
            if (RES_VALID === 1'b1) hs++;
            if (blk_done === 1'b1) begin
                done_seen = 1'b1;
                checks++;
                if (busy !== 1'b0 || COEF_READY !== 1'b0) begin
                    errors++;
                    $display("FAIL drop_idle: got busy=%b ready=%b expected 0 0", busy, COEF_READY);
                end
            end
            if (nacc == 2) ENABLE = 1'b0;
            cyc();
        end
        checks++;
        if (!done_seen || hs != 4 || nacc != 4) begin
            errors++;
            $display("FAIL drop_complete: got done=%b cols=%0d rows=%0d expected 1 4 4",
                     done_seen, hs, nacc);
        end
        for (int k = 0; k < 3; k++) begin
            #3;
            checks++;
            if (busy !== 1'b0 || COEF_READY !== 1'b0) begin
                errors++;
                $display("FAIL drop_stay_idle k=%0d: got busy=%b ready=%b expected 0 0",
                         k, busy, COEF_READY);
            end
            cyc();
        end
    endtask

    task automatic test_alternating();
        int hs = 0, lasts = 0, done_n = 0;
        do_reset();
        ENABLE = 1'b1; COEF_VALID = 1'b1;
        cyc();
        ENABLE = 1'b0;
        for (int k = 0; k < 40; k++) begin
            RES_READY = ((k % 2) == 0);
            #3;
            if (RES_VALID === 1'b1 && RES_READY === 1'b1) begin
                hs++;
                checks++;
                if (RES_LAST !== (hs == 4)) begin
                    errors++;
                    $display("FAIL alt_last hs=%0d: got %b expected %b", hs, RES_LAST, (hs == 4));
                end
            end
            if (RES_LAST === 1'b1 && RES_VALID === 1'b1 && RES_READY === 1'b1) lasts++;
            if (blk_done === 1'b1) done_n++;
            cyc();
        end
        checks++;
        if (hs != 4 || lasts != 1 || done_n != 1) begin
            errors++;
            $display("FAIL alt_totals: got hs=%0d lasts=%0d done=%0d expected 4 1 1", hs, lasts, done_n);
        end
    endtask

    task automatic test_reset_mid_out();
        int waited = 0;
        do_reset();
        ENABLE = 1'b1; COEF_VALID = 1'b1; RES_READY = 1'b0;
        cyc();
        ENABLE = 1'b0;
        #3;
        while (RES_VALID !== 1'b1 && waited < 20) begin
            cyc(); #3; waited++;
        end
        checks++;
        if (waited >= 20) begin
            errors++;
            $display("FAIL rst_wait: got no RES_VALID expected one within 20 cycles");
        end
        RESET = 1'b0;
        #1;
        checks++;
        if ({RES_VALID, RES_LAST, busy, en_dequant, en_vert, en_horz, en_round, blk_done,
             COEF_READY} !== 9'd0) begin
            errors++;
            $display("FAIL rst_async: got %b expected all zero",
                     {RES_VALID, RES_LAST, busy, en_dequant, en_vert, en_horz, en_round,
                      blk_done, COEF_READY});
        end
        cyc();
        RESET = 1'b1;
        for (int k = 0; k < 2; k++) begin
            cyc(); #3;
            checks++;
            if (COEF_READY !== 1'b0 || busy !== 1'b0 || RES_VALID !== 1'b0) begin
                errors++;
                $display("FAIL rst_after k=%0d: got ready=%b busy=%b valid=%b expected 0 0 0",
                         k, COEF_READY, busy, RES_VALID);
            end
        end
        ENABLE = 1'b1;
        cyc(); #3;
        checks++;
        if (COEF_READY !== 1'b1) begin
            errors++;
            $display("FAIL rst_restart: got ready=%b expected 1", COEF_READY);
        end
    endtask

    task automatic test_random();
        int         q_h[$];
        int         q_o[$];
        int         c;
        int         rows = 0, col_exp = 0, issue_exp = 0, blocks = 0;
        bit         p_deq = 1'b0, p_end = 1'b0, p_stall = 1'b0, p_last = 1'b0, end_now;
        logic [1:0] p_row = 2'd0;
        do_reset();
        for (int k = 0; k < 600; k++) begin
            ENABLE     = ($urandom_range(0, 3) != 0);
            COEF_VALID = 1'($urandom_range(0, 1));
            RES_READY  = 1'($urandom_range(0, 1));
            #3;
            end_now = 1'b0;
            checks++;
            if (en_dequant !== (COEF_VALID & COEF_READY) || en_vert !== p_deq || blk_done !== p_end) begin
                errors++;
                $display("FAIL rnd_ctrl k=%0d: got deq=%b vert=%b done=%b expected %b %b %b",
                         k, en_dequant, en_vert, blk_done, COEF_VALID & COEF_READY, p_deq, p_end);
            end
            if (p_deq) begin
                checks++;
                if (row_wr !== p_row) begin
                    errors++;
                    $display("FAIL rnd_row_wr k=%0d: got %0d expected %0d", k, row_wr, p_row);
                end
            end
            if (p_stall) begin
                checks++;
                if (RES_VALID !== 1'b1 || RES_LAST !== p_last) begin
                    errors++;
                    $display("FAIL rnd_hold k=%0d: got valid=%b last=%b expected 1 %b",
                             k, RES_VALID, RES_LAST, p_last);
                end
            end
            if (RES_VALID === 1'b1 && RES_READY === 1'b1) begin
                if (q_o.size() == 0) begin
                    c = -1;
                end else begin
                    c = q_o.pop_front();
                end
                checks++;
                if (c != col_exp || RES_LAST !== (c == 3)) begin
                    errors++;
                    $display("FAIL rnd_column k=%0d: got col=%0d last=%b expected col=%0d last=%b",
                             k, c, RES_LAST, col_exp, (col_exp == 3));
                end
                col_exp++;
                if (c == 3) begin
                    end_now   = 1'b1;
                    blocks++;
                    rows      = 0;
                    col_exp   = 0;
                    issue_exp = 0;
                end
            end
            if (en_round === 1'b1 && q_h.size() > 0) q_o.push_back(q_h.pop_front());
            if (en_horz === 1'b1) begin
                checks++;
                if (col_rd !== 2'(issue_exp) || rows != 4) begin
                    errors++;
                    $display("FAIL rnd_issue k=%0d: got col_rd=%0d rows=%0d expected %0d 4",
                             k, col_rd, rows, issue_exp);
                end
                q_h.push_back(int'(col_rd));
                issue_exp++;
            end
            if (en_dequant === 1'b1) begin
                checks++;
                if (rows >= 4) begin
                    errors++;
                    $display("FAIL rnd_extra_row k=%0d: got row accepted with %0d rows held expected none", k, rows);
                end
                p_row = 2'(rows);
                rows++;
            end
            p_deq   = (en_dequant === 1'b1);
            p_end   = end_now;
            p_stall = (RES_VALID === 1'b1) && (RES_READY === 1'b0);
            p_last  = (RES_LAST === 1'b1);
            cyc();
        end
        checks++;
        if (blocks < 5) begin
            errors++;
            $display("FAIL rnd_progress: got %0d blocks expected at least 5", blocks);
        end
    endtask

    initial begin
        RESET = 1'b0; ENABLE = 1'b0; COEF_VALID = 1'b0; RES_READY = 1'b0;
        test_reset();
        test_back_to_back();
        test_gaps();
        test_backpressure();
        test_enable_drop();
        test_alternating();
        test_reset_mid_out();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
